// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the junction phase controller: road codes, the
// phase state encoding and a road-to-lamp one-hot helper.
// No ports (package).
package traffic_pkg;

    localparam logic [1:0] ROAD_N = 2'd0;
    localparam logic [1:0] ROAD_E = 2'd1;
    localparam logic [1:0] ROAD_S = 2'd2;
    localparam logic [1:0] ROAD_W = 2'd3;

    typedef enum logic [1:0] {
        PH_ALLRED = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2
    } phase_e;

    // Lamp vector bit order matches the road codes (bit0=N ... bit3=W).
    function automatic logic [3:0] onehot4(input logic [1:0] road);
        onehot4 = 4'b0001 << road;
    endfunction

endpackage

// File: rtl/traffic_phase_controller_road_selector.sv
// road_selector
// Picks the road to serve after the current one. The three other roads are
// examined in rotation order starting after the current road; the first whose
// sensor average reaches SKIP_THRESH wins. If none qualifies, plain
// round-robin to the following road, so the current road is never re-picked.
// Ports:
//   avg_n_i/avg_e_i/avg_s_i/avg_w_i  per-road sensor averages
//   road_i                           road currently being served
//   next_o                           road chosen for the next green
module road_selector
    import traffic_pkg::*;
#(
    parameter int SKIP_THRESH = 4
) (
    input  logic [7:0] avg_n_i,
    input  logic [7:0] avg_e_i,
    input  logic [7:0] avg_s_i,
    input  logic [7:0] avg_w_i,
    input  logic [1:0] road_i,
    output logic [1:0] next_o
);

    logic [7:0] avgs [4];

    assign avgs[ROAD_N] = avg_n_i;
    assign avgs[ROAD_E] = avg_e_i;
    assign avgs[ROAD_S] = avg_s_i;
    assign avgs[ROAD_W] = avg_w_i;

    always_comb begin
        logic [1:0] cand;
        logic       found;
        next_o = road_i + 2'd1;
        cand   = road_i;
        found  = 1'b0;
        // 2-bit addition wraps naturally, giving the mod-4 rotation.
        for (int k = 1; k <= 3; k++) begin
            cand = road_i + 2'(k);
            if (!found && ({1'b0, avgs[cand]} >= 9'(SKIP_THRESH))) begin
                next_o = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller
// Sequences the junction through GREEN -> YELLOW -> ALLRED for one road at a
// time. Green length scales with the served road's sensor average, and roads
// with negligible traffic are skipped when choosing the next one. All phase
// timing advances only on the external tick enable.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   tick              one-cycle pulse per time unit
//   avg_n/e/s/w       per-road sensor averages
//   green, yellow     one-hot lamp vectors (bit0=N .. bit3=W)
//   all_red           high while in the clearance phase
//   active_road       road currently (or last) served
//   next_road         road scheduled for the next green, fed back to sensors
//   phase_remaining   ticks left in the current phase
//   phase_done        one-clock pulse after every phase transition
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN   = 5,
    parameter int MAX_GREEN   = 30,
    parameter int YELLOW_T    = 3,
    parameter int ALLRED_T    = 1,
    parameter int SHIFT       = 2,
    parameter int SKIP_THRESH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [7:0] avg_n,
    input  logic [7:0] avg_e,
    input  logic [7:0] avg_s,
    input  logic [7:0] avg_w,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic       all_red,
    output logic [1:0] active_road,
    output logic [1:0] next_road,
    output logic [7:0] phase_remaining,
    output logic       phase_done
);

    phase_e     state_q, state_d;
    logic [3:0] green_q, green_d;
    logic [3:0] yellow_q, yellow_d;
    logic       allRed_q, allRed_d;
    logic [1:0] activeRoad_q, activeRoad_d;
    logic [1:0] nextRoad_q, nextRoad_d;
    logic [7:0] remaining_q, remaining_d;
    logic       done_q, done_d;

    logic [1:0] selRoad;
    logic [7:0] nextAvg;

    // Sum is formed in 9 bits so a large average cannot wrap below MAX_GREEN.
    function automatic logic [7:0] gtime(input logic [7:0] a);
        logic [8:0] d;
        d = 9'(MIN_GREEN) + 9'(a >> SHIFT);
        if (d > 9'(MAX_GREEN)) gtime = 8'(MAX_GREEN);
        else                   gtime = d[7:0];
    endfunction

    road_selector #(
        .SKIP_THRESH(SKIP_THRESH)
    ) u_selector (
        .avg_n_i (avg_n),
        .avg_e_i (avg_e),
        .avg_s_i (avg_s),
        .avg_w_i (avg_w),
        .road_i  (activeRoad_q),
        .next_o  (selRoad)
    );

    always_comb begin
        case (nextRoad_q)
            ROAD_N:  nextAvg = avg_n;
            ROAD_E:  nextAvg = avg_e;
            ROAD_S:  nextAvg = avg_s;
            default: nextAvg = avg_w;
        endcase
    end

    // Phase sequencing: the timer counts down on tick, and on the last tick
    // of a phase the next phase's lamps and length are loaded together.
    always_comb begin
        state_d      = state_q;
        green_d      = green_q;
        yellow_d     = yellow_q;
        allRed_d     = allRed_q;
        activeRoad_d = activeRoad_q;
        nextRoad_d   = nextRoad_q;
        remaining_d  = remaining_q;
        done_d       = 1'b0;

        if (tick && (remaining_q > 8'd1)) begin
            remaining_d = remaining_q - 8'd1;
        end else if (tick) begin
            done_d = 1'b1;
            case (state_q)
                PH_ALLRED: begin
                    state_d      = PH_GREEN;
                    activeRoad_d = nextRoad_q;
                    green_d      = onehot4(nextRoad_q);
                    allRed_d     = 1'b0;
                    remaining_d  = gtime(nextAvg);
                end
                PH_GREEN: begin
                    state_d     = PH_YELLOW;
                    yellow_d    = onehot4(activeRoad_q);
                    green_d     = 4'd0;
                    remaining_d = 8'(YELLOW_T);
                    nextRoad_d  = selRoad;
                end
                default: begin
                    // Also recovers the unused encoding into a safe all-red.
                    state_d     = PH_ALLRED;
                    green_d     = 4'd0;
                    yellow_d    = 4'd0;
                    allRed_d    = 1'b1;
                    remaining_d = 8'(ALLRED_T);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PH_ALLRED;
            green_q      <= 4'd0;
            yellow_q     <= 4'd0;
            allRed_q     <= 1'b1;
            activeRoad_q <= ROAD_N;
            nextRoad_q   <= ROAD_N;
            remaining_q  <= 8'(ALLRED_T);
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            green_q      <= green_d;
            yellow_q     <= yellow_d;
            allRed_q     <= allRed_d;
            activeRoad_q <= activeRoad_d;
            nextRoad_q   <= nextRoad_d;
            remaining_q  <= remaining_d;
            done_q       <= done_d;
        end
    end

    assign green           = green_q;
    assign yellow          = yellow_q;
    assign all_red         = allRed_q;
    assign active_road     = activeRoad_q;
    assign next_road       = nextRoad_q;
    assign phase_remaining = remaining_q;
    assign phase_done      = done_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller
// Directed bench for the junction phase controller with default parameters.
// Expected lamp sequences and green lengths are hand-computed from the
// sensor averages driven in each scenario.
module tb_traffic_phase_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] avg_n = 8'd0;
    logic [7:0] avg_e = 8'd0;
    logic [7:0] avg_s = 8'd0;
    logic [7:0] avg_w = 8'd0;
    logic [3:0] green;
    logic [3:0] yellow;
    logic       all_red;
    logic [1:0] active_road;
    logic [1:0] next_road;
    logic [7:0] phase_remaining;
    logic       phase_done;

    int checkCount = 0;
    int errCount   = 0;

    traffic_phase_controller dut (
        .clk             (clk),
        .reset           (reset),
        .tick            (tick),
        .avg_n           (avg_n),
        .avg_e           (avg_e),
        .avg_s           (avg_s),
        .avg_w           (avg_w),
        .green           (green),
        .yellow          (yellow),
        .all_red         (all_red),
        .active_road     (active_road),
        .next_road       (next_road),
        .phase_remaining (phase_remaining),
        .phase_done      (phase_done)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Single point of comparison: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives tick for one clock and returns 1 time unit after the edge.
    task automatic applyStimulus(input logic t);
        tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b1);
        reset = 1'b0;
    endtask

    task automatic setAvgs(input logic [7:0] n, input logic [7:0] e,
                           input logic [7:0] s, input logic [7:0] w);
        avg_n = n;
        avg_e = e;
        avg_s = s;
        avg_w = w;
    endtask

    function automatic int roadOf(input logic [3:0] g);
        case (g)
            4'b0001: roadOf = 0;
            4'b0010: roadOf = 1;
            4'b0100: roadOf = 2;
            4'b1000: roadOf = 3;
            default: roadOf = -1;
        endcase
    endfunction

    // Ticks every cycle until a green appears, then measures how many cycles
    // it stays lit. Returns at the first yellow cycle.
    task automatic waitGreen(output int road, output int len);
        int n;
        road = -1;
        len  = 0;
        n    = 1;
        applyStimulus(1'b1);
        while (green == 4'd0 && n < 200) begin
            applyStimulus(1'b1);
            n++;
        end
        if (green == 4'd0) begin
            checkOutput("green_timeout", 32'd0, 32'd1);
            return;
        end
        road = roadOf(green);
        len  = 1;
        n    = 0;
        while (n < 100) begin
            applyStimulus(1'b1);
            n++;
            if (green == 4'd0) break;
            len++;
        end
        if (green != 4'd0) begin
            checkOutput("green_end_timeout", 32'd0, 32'd1);
            return;
        end
        checkOutput("yellow_follows", 32'(yellow), 32'(4'b0001 << road));
    endtask

    task automatic expectGreens(input string tag, input int roads[], input int lens[]);
        int r, l;
        foreach (roads[i]) begin
            waitGreen(r, l);
            checkOutput({tag, "_road"}, r, roads[i]);
            checkOutput({tag, "_len"}, l, lens[i]);
        end
    endtask

    initial begin
        int r, l;
        bit doneSeen;

        // Scenario 1: reset state and one full N cycle with all averages 12.
        setAvgs(8'd12, 8'd12, 8'd12, 8'd12);
        doReset();
        checkOutput("rst_all_red", all_red, 1);
        checkOutput("rst_green", green, 0);
        checkOutput("rst_yellow", yellow, 0);
        checkOutput("rst_remaining", phase_remaining, 1);
        checkOutput("rst_next_road", next_road, 0);
        checkOutput("rst_active_road", active_road, 0);
        checkOutput("rst_done", phase_done, 0);

        applyStimulus(1'b1);
        checkOutput("s1_green_n", green, 4'b0001);
        checkOutput("s1_all_red_off", all_red, 0);
        checkOutput("s1_gtime12", phase_remaining, 8);
        checkOutput("s1_done_g", phase_done, 1);
        applyStimulus(1'b1);
        checkOutput("s1_dec", phase_remaining, 7);
        checkOutput("s1_done_low", phase_done, 0);
        repeat (6) applyStimulus(1'b1);
        checkOutput("s1_last_green_rem", phase_remaining, 1);
        checkOutput("s1_still_green", green, 4'b0001);
        applyStimulus(1'b1);
        checkOutput("s1_yellow_n", yellow, 4'b0001);
        checkOutput("s1_green_off", green, 0);
        checkOutput("s1_yellow_rem", phase_remaining, 3);
        checkOutput("s1_done_y", phase_done, 1);
        checkOutput("s1_next_e", next_road, 1);
        repeat (2) applyStimulus(1'b1);
        checkOutput("s1_yellow_hold", yellow, 4'b0001);
        applyStimulus(1'b1);
        checkOutput("s1_allred", all_red, 1);
        checkOutput("s1_allred_yellow", yellow, 0);
        checkOutput("s1_allred_rem", phase_remaining, 1);
        checkOutput("s1_done_r", phase_done, 1);
        applyStimulus(1'b1);
        checkOutput("s1_green_e", green, 4'b0010);
        checkOutput("s1_active_e", active_road, 1);
        checkOutput("s1_green_e_rem", phase_remaining, 8);

        // Scenario 2: east below threshold is skipped; others get 5+20/4=10.
        setAvgs(8'd20, 8'd2, 8'd20, 8'd20);
        doReset();
        waitGreen(r, l);
        checkOutput("s2_first_road", r, 0);
        checkOutput("s2_first_len", l, 10);
        checkOutput("s2_next_skips_e", next_road, 2);
        expectGreens("s2", '{2, 3, 0, 2, 3}, '{10, 10, 10, 10, 10});

        // Scenario 3: nobody qualifies, so strict round-robin at MIN_GREEN.
        setAvgs(8'd1, 8'd1, 8'd1, 8'd1);
        doReset();
        expectGreens("s3", '{0, 1, 2, 3, 0}, '{5, 5, 5, 5, 5});

        // Scenario 4: west green clamps at MAX_GREEN; zero averages give MIN.
        setAvgs(8'd12, 8'd12, 8'd12, 8'd200);
        doReset();
        expectGreens("s4a", '{0, 1, 2, 3}, '{8, 8, 8, 30});
        avg_w = 8'd255;
        expectGreens("s4b", '{0, 1, 2, 3}, '{8, 8, 8, 30});
        setAvgs(8'd0, 8'd0, 8'd0, 8'd0);
        expectGreens("s4c", '{0, 1, 2, 3}, '{5, 5, 5, 5});

        // Scenario 5: tick held low mid-green freezes everything.
        setAvgs(8'd12, 8'd12, 8'd12, 8'd12);
        doReset();
        repeat (3) applyStimulus(1'b1);
        checkOutput("s5_pre_rem", phase_remaining, 6);
        doneSeen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0);
            if (phase_done) doneSeen = 1'b1;
        end
        checkOutput("s5_frozen_rem", phase_remaining, 6);
        checkOutput("s5_frozen_green", green, 4'b0001);
        checkOutput("s5_frozen_yellow", yellow, 0);
        checkOutput("s5_frozen_all_red", all_red, 0);
        checkOutput("s5_no_done", doneSeen, 0);
        applyStimulus(1'b1);
        checkOutput("s5_resume_rem", phase_remaining, 5);

        // Scenario 6: reset during east's yellow goes straight to all-red.
        doReset();
        expectGreens("s6", '{0, 1}, '{8, 8});
        checkOutput("s6_in_yellow_e", yellow, 4'b0010);
        doReset();
        checkOutput("s6_rst_all_red", all_red, 1);
        checkOutput("s6_rst_yellow", yellow, 0);
        checkOutput("s6_rst_green", green, 0);
        checkOutput("s6_rst_next", next_road, 0);
        checkOutput("s6_rst_rem", phase_remaining, 1);
        checkOutput("s6_rst_done", phase_done, 0);
        waitGreen(r, l);
        checkOutput("s6_after_rst_road", r, 0);
        checkOutput("s6_after_rst_len", l, 8);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
